// File: rtl/dac_spi_pkg.sv
// Shared types and helpers for the DAC SPI output stage.
// State encoding, default command prefix, offset-binary conversion.
package dac_spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD
  } state_e;

  localparam logic [3:0] CMD_DEFAULT = 4'b0011;

  // Flip the sample MSB to turn two's complement into offset binary.
  function automatic logic [31:0] to_offset(
    input logic [31:0] s,
    input int          w,
    input logic        inv
  );
    return s ^ ({31'b0, inv} << (w - 1));
  endfunction

endpackage

// File: rtl/dac_spi_tick_gen.sv
// Divider tick: fires every CLK_DIV cycles, restartable.
// pre_tick fires one cycle ahead of tick when CLK_DIV > 1.
module dac_spi_tick_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic CLK_SYS,
  input  logic nRST,
  input  logic restart,
  output logic tick,
  output logic pre_tick
);

  localparam int CW  = $clog2(CLK_DIV + 1);
  localparam int PRE = (CLK_DIV > 1) ? CLK_DIV - 2 : 0;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick     = (cnt_q == CW'(CLK_DIV - 1));
    pre_tick = (CLK_DIV > 1) && (cnt_q == CW'(PRE));
    cnt_d    = cnt_q + 1'b1;
    if (restart || tick)
      cnt_d = '0;
  end

  always_ff @(posedge CLK_SYS or negedge nRST)
    if (!nRST) cnt_q <= '0;
    else       cnt_q <= cnt_d;

endmodule

// File: rtl/dac_spi_tx.sv
// SPI mode-0 DAC frame transmitter with FRAME_DONE pacing pulse.
// Optional LDAC_N strobe when DAC_SPI_TX_LDAC_EN is defined.
module dac_spi_tx
  import dac_spi_pkg::*;
#(
  parameter int DATA_WIDTH  = 12,
  parameter int CMD_WIDTH   = 4,
  parameter logic [CMD_WIDTH-1:0] CMD_VALUE =
    CMD_WIDTH'(CMD_DEFAULT),
  parameter int FRAME_WIDTH = 16,
  parameter int CLK_DIV     = 2,
  parameter int SIGNED_IN   = 1
) (
  input  logic                  CLK_SYS,
  input  logic                  nRST,
  input  logic                  EN,
  input  logic [DATA_WIDTH-1:0] DATA_IN,
  input  logic                  DATA_VALID,
  output logic                  DATA_READY,
  output logic                  FRAME_DONE,
  output logic                  SPI_SCLK,
  output logic                  SPI_MOSI,
  output logic                  SPI_CS_N
`ifdef DAC_SPI_TX_LDAC_EN
  ,
  output logic                  LDAC_N
`endif
);

  localparam int FW = FRAME_WIDTH;
  localparam int BW = $clog2(FRAME_WIDTH + 1);

  state_e        state_q, state_d;
  logic [FW-1:0] sh_q, sh_d;
  logic [BW-1:0] bit_q, bit_d;
  logic          sclk_q, sclk_d;
  logic          cs_n_q, cs_n_d;
  logic          mosi_q, mosi_d;
  logic          done_q, done_d;
`ifdef DAC_SPI_TX_LDAC_EN
  logic          ldac_n_q, ldac_n_d;
  logic          ph_q, ph_d;
`endif

  logic                  tick, pre_tick, restart;
  logic [DATA_WIDTH-1:0] conv;
  logic [FW-1:0]         frame;

  dac_spi_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .CLK_SYS  (CLK_SYS),
    .nRST     (nRST),
    .restart  (restart),
    .tick     (tick),
    .pre_tick (pre_tick)
  );

  always_comb begin
    conv = DATA_WIDTH'(to_offset(
      32'(DATA_IN), DATA_WIDTH, SIGNED_IN != 0));
    frame = '0;
    frame[FW-1 -: CMD_WIDTH] = CMD_VALUE;
    frame[FW-CMD_WIDTH-1 -: DATA_WIDTH] = conv;
  end

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    bit_d   = bit_q;
    sclk_d  = sclk_q;
    cs_n_d  = cs_n_q;
    mosi_d  = mosi_q;
    done_d  = 1'b0;
`ifdef DAC_SPI_TX_LDAC_EN
    ldac_n_d = ldac_n_q;
    ph_d     = ph_q;
`endif
    if (!EN) begin
      state_d = IDLE;
      cs_n_d  = 1'b1;
      sclk_d  = 1'b0;
      mosi_d  = 1'b0;
`ifdef DAC_SPI_TX_LDAC_EN
      ldac_n_d = 1'b1;
      ph_d     = 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
`ifdef DAC_SPI_TX_LDAC_EN
          ldac_n_d = 1'b1;
          ph_d     = 1'b0;
`endif
          if (DATA_VALID) begin
            state_d = SETUP;
            sh_d    = frame;
            bit_d   = BW'(FW - 1);
            cs_n_d  = 1'b0;
            sclk_d  = 1'b0;
            mosi_d  = frame[FW-1];
          end
        end
        SETUP: begin
          if (tick) begin
            state_d = SHIFT;
            sclk_d  = 1'b1;
          end
        end
        SHIFT: begin
          if (tick && sclk_q) begin
            sclk_d = 1'b0;
            sh_d   = sh_q << 1;
            mosi_d = sh_q[FW-2];
          end else if (tick && bit_q == '0) begin
            cs_n_d  = 1'b1;
            mosi_d  = 1'b0;
            state_d = HOLD;
`ifndef DAC_SPI_TX_LDAC_EN
            if (CLK_DIV == 1) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
`endif
          end else if (tick) begin
            bit_d  = bit_q - 1'b1;
            sclk_d = 1'b1;
          end
        end
        HOLD: begin
          // The FRAME_DONE/IDLE cycle counts toward the
          // CS_N-high (and LDAC_N-low) intervals.
`ifdef DAC_SPI_TX_LDAC_EN
          if (!ph_q && tick) begin
            ph_d     = 1'b1;
            ldac_n_d = 1'b0;
            if (CLK_DIV == 1) begin
              state_d = IDLE;
              done_d  = 1'b1;
              ph_d    = 1'b0;
            end
          end else if (ph_q && pre_tick) begin
            state_d = IDLE;
            done_d  = 1'b1;
            ph_d    = 1'b0;
          end
`else
          if (pre_tick) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
`endif
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign restart = (state_d != state_q);

  always_ff @(posedge CLK_SYS or negedge nRST)
    if (!nRST) begin
      state_q <= IDLE;
      sh_q    <= '0;
      bit_q   <= '0;
      sclk_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      mosi_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef DAC_SPI_TX_LDAC_EN
      ldac_n_q <= 1'b1;
      ph_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      bit_q   <= bit_d;
      sclk_q  <= sclk_d;
      cs_n_q  <= cs_n_d;
      mosi_q  <= mosi_d;
      done_q  <= done_d;
`ifdef DAC_SPI_TX_LDAC_EN
      ldac_n_q <= ldac_n_d;
      ph_q     <= ph_d;
`endif
    end

  assign DATA_READY = EN && (state_q == IDLE);
  assign FRAME_DONE = done_q;
  assign SPI_SCLK   = sclk_q;
  assign SPI_MOSI   = mosi_q;
  assign SPI_CS_N   = cs_n_q;
`ifdef DAC_SPI_TX_LDAC_EN
  assign LDAC_N     = ldac_n_q;
`endif

endmodule
